// File: rtl/i_cache_if.sv
// Sram-like request/response bundle used on both the CPU side and the bridge side
// of the instruction cache: the master issues req/addr, the slave answers addr_ok/data_ok.
`timescale 1ns/1ps
interface i_cache_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok
  );
endinterface

// File: rtl/i_cache.sv
// Direct-mapped, read-only instruction cache with one 32-bit word per line.
// Hits return data the cycle after acceptance; misses and uncached fetches go to the bridge.
`timescale 1ns/1ps
module i_cache #(
  parameter int INDEX_WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      inst_uncached,
  i_cache_if.slave  cpu_inst,
  i_cache_if.master cache_inst
);
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 30 - INDEX_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_MISS   = 2'd2,
    S_REFILL = 2'd3
  } state_t;

  state_t                 r_state;
  logic [31:0]            r_addr;
  logic                   r_uncached;
  logic [LINES-1:0]       r_valid;
  logic [TAG_W-1:0]       r_tag  [LINES];
  logic [31:0]            r_data [LINES];

  logic [INDEX_WIDTH-1:0] w_index;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_hit;
  logic                   w_accept;
  logic                   w_fill;
  logic                   w_cpu_addr_ok;
  logic                   w_cpu_data_ok;
  logic [31:0]            w_cpu_rdata;
  logic                   w_cache_req;
  logic                   w_unused;

  assign w_index  = r_addr[INDEX_WIDTH+1:2];
  assign w_tag    = r_addr[31:INDEX_WIDTH+2];
  assign w_hit    = ~r_uncached & r_valid[w_index] & (r_tag[w_index] == w_tag);
  assign w_accept = cpu_inst.req & w_cpu_addr_ok;
  assign w_fill   = (r_state == S_REFILL) & cache_inst.data_ok & ~r_uncached & ~rst;

  // Handshake and data outputs; everything is forced low while reset is asserted.
  always_comb begin
    w_cpu_addr_ok = 1'b0;
    w_cpu_data_ok = 1'b0;
    w_cpu_rdata   = 32'h0000_0000;
    w_cache_req   = 1'b0;
    if (rst) begin
      w_cpu_addr_ok = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cpu_addr_ok = cpu_inst.req;
        end
        S_LOOKUP: begin
          if (w_hit) begin
            w_cpu_data_ok = 1'b1;
            w_cpu_rdata   = r_data[w_index];
            w_cpu_addr_ok = cpu_inst.req;
          end else begin
            w_cpu_addr_ok = 1'b0;
          end
        end
        S_MISS: begin
          w_cache_req = 1'b1;
        end
        S_REFILL: begin
          if (cache_inst.data_ok) begin
            w_cpu_data_ok = 1'b1;
            w_cpu_rdata   = cache_inst.rdata;
          end else begin
            w_cpu_data_ok = 1'b0;
          end
        end
        default: begin
          w_cpu_addr_ok = 1'b0;
        end
      endcase
    end
  end

  // Control FSM: latches each accepted fetch and tracks the valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_valid    <= {LINES{1'b0}};
      r_addr     <= 32'h0000_0000;
      r_uncached <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr     <= cpu_inst.addr;
            r_uncached <= inst_uncached;
            r_state    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (!w_hit) begin
            r_state <= S_MISS;
          end else if (w_accept) begin
            r_addr     <= cpu_inst.addr;
            r_uncached <= inst_uncached;
            r_state    <= S_LOOKUP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MISS: begin
          if (cache_inst.addr_ok) begin
            r_state <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (cache_inst.data_ok) begin
            if (!r_uncached) begin
              r_valid[w_index] <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Tag and data storage; a refill simply overwrites whatever the line held.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_index]  <= w_tag;
      r_data[w_index] <= cache_inst.rdata;
    end
  end

  assign cpu_inst.addr_ok = w_cpu_addr_ok;
  assign cpu_inst.data_ok = w_cpu_data_ok;
  assign cpu_inst.rdata   = w_cpu_rdata;

  assign cache_inst.req   = w_cache_req;
  assign cache_inst.addr  = r_addr;
  assign cache_inst.wr    = 1'b0;
  assign cache_inst.size  = 2'b10;
  assign cache_inst.wdata = 32'h0000_0000;

  // Fetches are always word reads, so the CPU write fields carry no information.
  assign w_unused = ^{cpu_inst.wr, cpu_inst.size, cpu_inst.wdata};
endmodule

// File: tb/tb_i_cache.sv
// Scoreboard bench for i_cache: a driver predicts hit/miss from an abstract line model,
// a responder emulates the bridge, and a monitor compares every returned word.
`timescale 1ns/1ps
module tb_i_cache;
  localparam int IW    = 8;
  localparam int LINES = 1 << IW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inst_uncached = 1'b0;

  i_cache_if cpu_inst();
  i_cache_if cache_inst();

  i_cache #(.INDEX_WIDTH(IW)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_uncached (inst_uncached),
    .cpu_inst      (cpu_inst),
    .cache_inst    (cache_inst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          hit;
    bit          unc;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] dn_q[$];
  bit [31:0]   mem_ovr [bit [31:0]];
  bit          line_v  [int];
  bit [31:0]   line_a  [int];

  int          rsp_dly   = 3;
  int          rsp_stall = 0;
  bit          rsp_rand  = 1'b0;
  int          rsp_stage = 0;
  int          rsp_cnt   = 0;
  logic [31:0] rsp_addr  = 32'h0;
  int          hs_count  = 0;
  int          stall_obs = 0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fetch(input logic [31:0] a, input bit unc);
    int   n;
    int   idx;
    bit   hit;
    exp_t e;
    @(negedge clk);
    cpu_inst.req   = 1'b1;
    cpu_inst.addr  = a;
    inst_uncached  = unc;
    cpu_inst.wr    = 1'($urandom);
    cpu_inst.size  = 2'($urandom);
    cpu_inst.wdata = $urandom;
    #1;
    n = 0;
    while (!cpu_inst.addr_ok && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cpu_inst.addr_ok) begin
      chk(1'b0, "accept_timeout", a, 32'h0);
      cpu_inst.req = 1'b0;
      return;
    end
    idx    = int'((a >> 2) % LINES);
    hit    = !unc && line_v.exists(idx) && (line_a[idx] == a);
    e.addr = a;
    e.data = mem_word(a);
    e.hit  = hit;
    e.unc  = unc;
    e.cyc  = cyc;
    exp_q.push_back(e);
    if (!hit) dn_q.push_back(a);
  endtask

  task automatic idle();
    @(negedge clk);
    cpu_inst.req  = 1'b0;
    inst_uncached = 1'b0;
  endtask

  task automatic drain();
    int n;
    idle();
    n = 0;
    while ((exp_q.size() != 0 || rsp_stage != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(exp_q.size() == 0, "drain", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst           = 1'b1;
    cpu_inst.req  = 1'b1;
    cpu_inst.addr = 32'h1FC0_0000;
    inst_uncached = 1'b0;
    exp_q.delete();
    dn_q.delete();
    line_v.delete();
    line_a.delete();
    #1;
    chk(cpu_inst.addr_ok == 1'b0, "rst_cpu_addr_ok", 32'(cpu_inst.addr_ok), 32'h0);
    chk(cpu_inst.data_ok == 1'b0, "rst_cpu_data_ok", 32'(cpu_inst.data_ok), 32'h0);
    chk(cache_inst.req == 1'b0, "rst_cache_req", 32'(cache_inst.req), 32'h0);
    repeat (cycles - 1) @(negedge clk);
    @(negedge clk);
    rst          = 1'b0;
    cpu_inst.req = 1'b0;
    #1;
    chk(cpu_inst.addr_ok == 1'b0, "post_rst_addr_ok", 32'(cpu_inst.addr_ok), 32'h0);
    chk(cpu_inst.data_ok == 1'b0, "post_rst_data_ok", 32'(cpu_inst.data_ok), 32'h0);
    chk(cache_inst.req == 1'b0, "post_rst_cache_req", 32'(cache_inst.req), 32'h0);
    chk(cpu_inst.rdata == 32'h0, "post_rst_rdata", cpu_inst.rdata, 32'h0);
  endtask

  // Bridge emulation: accepts one request, returns the memory word after a delay,
  // and pulses stray data_ok while idle to show it is ignored outside a refill.
  initial begin
    logic [31:0] a;
    cache_inst.addr_ok = 1'b0;
    cache_inst.data_ok = 1'b0;
    cache_inst.rdata   = 32'h0;
    forever begin
      @(negedge clk);
      cache_inst.data_ok = 1'b0;
      cache_inst.addr_ok = 1'b0;
      cache_inst.rdata   = 32'h0;
      if (rsp_stage == 1) begin
        if (rsp_cnt <= 0) begin
          cache_inst.data_ok = 1'b1;
          cache_inst.rdata   = mem_word(rsp_addr);
        end else if (rsp_rand) begin
          cache_inst.rdata = $urandom;
        end
      end else begin
        if (rsp_rand) begin
          cache_inst.data_ok = ($urandom_range(0, 3) == 0);
          cache_inst.rdata   = $urandom;
        end
        if (rsp_stall > 0) cache_inst.addr_ok = 1'b0;
        else if (rsp_rand) cache_inst.addr_ok = 1'($urandom_range(0, 1));
        else cache_inst.addr_ok = 1'b1;
      end
      #1;
      if (rst) begin
        rsp_stage = 0;
        prev_wait = 1'b0;
      end else if (rsp_stage == 1) begin
        if (cache_inst.req) chk(1'b0, "req_in_refill", 32'(cache_inst.req), 32'h0);
        if (cache_inst.data_ok) rsp_stage = 0;
        else rsp_cnt--;
      end else begin
        if (prev_wait) begin
          chk(cache_inst.req == 1'b1, "stall_req_held", 32'(cache_inst.req), 32'h1);
          chk(cache_inst.addr == prev_addr, "stall_addr_stable", cache_inst.addr, prev_addr);
          chk(cpu_inst.addr_ok == 1'b0, "stall_cpu_addr_ok", 32'(cpu_inst.addr_ok), 32'h0);
        end
        if (cache_inst.req) begin
          if (cache_inst.addr_ok) begin
            hs_count++;
            chk(cache_inst.wr == 1'b0 && cache_inst.size == 2'b10 && cache_inst.wdata == 32'h0,
                "bus_consts", {cache_inst.wdata[28:0], cache_inst.wr, cache_inst.size}, 32'h2);
            if (dn_q.size() == 0) begin
              chk(1'b0, "unexpected_downstream", cache_inst.addr, 32'h0);
            end else begin
              a = dn_q.pop_front();
              chk(cache_inst.addr == a, "downstream_addr", cache_inst.addr, a);
            end
            rsp_stage = 1;
            rsp_addr  = cache_inst.addr;
            rsp_cnt   = (rsp_rand ? $urandom_range(1, 4) : rsp_dly) - 1;
            prev_wait = 1'b0;
          end else begin
            prev_wait = 1'b1;
            prev_addr = cache_inst.addr;
            if (rsp_stall > 0) begin
              rsp_stall--;
              stall_obs++;
            end
          end
        end else begin
          prev_wait = 1'b0;
        end
      end
    end
  end

  // Monitor: every CPU data_ok must match the oldest expectation; cached refills update the model.
  initial begin
    exp_t e;
    int   idx;
    forever begin
      @(negedge clk);
      #2;
      if (cpu_inst.data_ok) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "spurious_data_ok", cpu_inst.rdata, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk(cpu_inst.rdata == e.data, "rdata", cpu_inst.rdata, e.data);
          if (e.hit) begin
            chk(cyc == e.cyc + 1, "hit_latency", cyc, e.cyc + 1);
          end else if (!e.unc) begin
            idx         = int'((e.addr >> 2) % LINES);
            line_v[idx] = 1'b1;
            line_a[idx] = e.addr;
          end
        end
      end
    end
  end

  initial begin
    int          h0;
    int          n;
    logic [31:0] a;
    bit          unc;
    cpu_inst.req   = 1'b0;
    cpu_inst.wr    = 1'b0;
    cpu_inst.size  = 2'b00;
    cpu_inst.addr  = 32'h0;
    cpu_inst.wdata = 32'h0;
    mem_ovr[32'h1FC0_0000] = 32'h3C08_0001;

    do_reset(3);

    h0 = hs_count;
    fetch(32'h1FC0_0000, 1'b0);
    drain();
    chk(hs_count == h0 + 1, "cold_miss_requests", 32'(hs_count - h0), 32'h1);

    fetch(32'h1FC0_0004, 1'b0);
    drain();

    h0 = hs_count;
    fetch(32'h1FC0_0000, 1'b0);
    fetch(32'h1FC0_0004, 1'b0);
    drain();
    chk(hs_count == h0, "hit_stream_no_request", 32'(hs_count - h0), 32'h0);

    h0 = hs_count;
    fetch(32'h1FC0_0008, 1'b1);
    fetch(32'h1FC0_0008, 1'b1);
    drain();
    chk(hs_count == h0 + 2, "uncached_requests", 32'(hs_count - h0), 32'h2);
    h0 = hs_count;
    fetch(32'h1FC0_0008, 1'b0);
    drain();
    chk(hs_count == h0 + 1, "index2_still_invalid", 32'(hs_count - h0), 32'h1);

    h0 = hs_count;
    fetch(32'h1FC0_0400, 1'b0);
    drain();
    fetch(32'h1FC0_0000, 1'b0);
    drain();
    chk(hs_count == h0 + 2, "conflict_refetch_miss", 32'(hs_count - h0), 32'h2);

    stall_obs = 0;
    rsp_stall = 5;
    fetch(32'h1FC0_0010, 1'b0);
    drain();
    chk(stall_obs == 5, "stall_cycles", 32'(stall_obs), 32'h5);

    rsp_dly = 8;
    h0 = hs_count;
    fetch(32'h1FC0_0020, 1'b0);
    n = 0;
    while (hs_count == h0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(hs_count == h0 + 1, "midrefill_handshake", 32'(hs_count - h0), 32'h1);
    repeat (2) @(negedge clk);
    do_reset(2);
    rsp_dly = 3;
    h0 = hs_count;
    fetch(32'h1FC0_0020, 1'b0);
    drain();
    chk(hs_count == h0 + 1, "post_reset_refetch_miss", 32'(hs_count - h0), 32'h1);

    rsp_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      a   = 32'h1FC0_0000 + 32'($urandom_range(0, 2)) * 32'h400 + 32'($urandom_range(0, 15)) * 32'h4;
      unc = ($urandom_range(0, 7) == 0);
      fetch(a, unc);
      if ($urandom_range(0, 3) == 0) idle();
    end
    drain();
    rsp_rand = 1'b0;
    chk(dn_q.size() == 0, "downstream_queue_empty", 32'(dn_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
